// File: rtl/spi_slave_regfile_pkg.sv
// Shared constants and types for the SPI slave register file.
`timescale 1ns/1ps
package spi_slave_regfile_pkg;

    localparam int unsigned CMD_RW_BIT  = 7;
    localparam int unsigned CMD_ADDR_HI = 6;
    localparam int unsigned CMD_ADDR_LO = 0;

    localparam int unsigned SYNC_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/spi_slv_pin_sync.sv
// SPI pin synchronisers with SCK/CS edge detection and CPOL/CPHA decoding.
`timescale 1ns/1ps
module spi_slv_pin_sync
    import spi_slave_regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cpol,
    input  logic cpha,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    output logic sample_stb,
    output logic shift_stb,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [SYNC_DEPTH-1:0] cs_sync;
    logic [SYNC_DEPTH-1:0] sck_sync;
    logic [SYNC_DEPTH-1:0] mosi_sync;
    logic                  cs_d;
    logic                  sck_d;
    logic                  cs_s;
    logic                  sck_s;
    logic                  lead_edge;
    logic                  trail_edge;

    // CS resets to "asserted" so a frame already in progress at reset release
    // is not mistaken for a new falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b0;
            sck_d     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_DEPTH-2:0], cs_n};
            sck_sync  <= {sck_sync[SYNC_DEPTH-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi};
            cs_d      <= cs_sync[SYNC_DEPTH-1];
            sck_d     <= sck_sync[SYNC_DEPTH-1];
        end
    end

    always_comb begin
        cs_s       = cs_sync[SYNC_DEPTH-1];
        sck_s      = sck_sync[SYNC_DEPTH-1];
        mosi_s     = mosi_sync[SYNC_DEPTH-1];
        lead_edge  = (sck_s != sck_d) && (sck_d == cpol);
        trail_edge = (sck_s != sck_d) && (sck_s == cpol);
        sample_stb = cpha ? trail_edge : lead_edge;
        shift_stb  = cpha ? lead_edge  : trail_edge;
        cs_fall    = cs_d & ~cs_s;
        cs_rise    = ~cs_d & cs_s;
    end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave exposing a bank of 8-bit registers; command byte = {R/nW, addr[6:0]}.
// Define SPI_SLV_ADDR_WRAP_EN to wrap the auto-increment from NREGS-1 back to 0.
`timescale 1ns/1ps
module spi_slave_regfile
    import spi_slave_regfile_pkg::*;
#(
    parameter int unsigned NREGS   = 16,
    parameter int unsigned AW      = $clog2(NREGS),
    parameter logic [7:0]  REG_RST = 8'h00
) (
    input  logic               S_SYSCLK,
    input  logic               S_RESETN,
    input  logic               S_ENABLE,
    input  logic               S_CPOL,
    input  logic               S_CPHA,
    input  logic               S_SPI_CS,
    input  logic               S_SPI_SCK,
    input  logic               S_SPI_MOSI,
    output logic               S_SPI_MISO,
    output logic               S_SPI_MISO_OE,
    output logic [NREGS*8-1:0] S_REGS,
    output logic               S_WR_STB,
    output logic [AW-1:0]      S_WR_ADDR,
    output logic [7:0]         S_WR_DATA,
    output logic               S_FRAME_DONE
);

    localparam logic [7:0] NREGS_W = 8'(NREGS);
`ifdef SPI_SLV_ADDR_WRAP_EN
    localparam logic [6:0] LAST_ADDR = 7'(NREGS - 1);
`endif

    state_t     state;
    state_t     state_nxt;
    logic       sample_stb;
    logic       shift_stb;
    logic       cs_fall;
    logic       cs_rise;
    logic       mosi_s;
    logic [7:0] regs [NREGS];
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic [2:0] bit_cnt;
    logic [6:0] addr;
    logic       rw;
    logic       miso_q;
    logic       start;
    logic       end_frame;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [6:0] cmd_addr;

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        logic [6:0] nxt;
        nxt = (a == 7'h7F) ? a : a + 7'd1;
`ifdef SPI_SLV_ADDR_WRAP_EN
        if (a == LAST_ADDR) nxt = '0;
`endif
        return nxt;
    endfunction

    function automatic logic [7:0] rd_reg(input logic [6:0] a);
        return in_range(a) ? regs[a[AW-1:0]] : 8'h00;
    endfunction

    spi_slv_pin_sync u_pin_sync (
        .clk        (S_SYSCLK),
        .rst_n      (S_RESETN),
        .cpol       (S_CPOL),
        .cpha       (S_CPHA),
        .cs_n       (S_SPI_CS),
        .sck        (S_SPI_SCK),
        .mosi       (S_SPI_MOSI),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise),
        .mosi_s     (mosi_s)
    );

    // Disabling the block mid-frame is treated exactly like a CS rise.
    always_comb begin
        start     = cs_fall & S_ENABLE;
        end_frame = cs_rise | ~S_ENABLE;
        byte_done = sample_stb & (bit_cnt == 3'd7);
        rx_byte   = {rx_sr, mosi_s};
        cmd_addr  = rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_CMD;
            ST_CMD: begin
                if (end_frame)      state_nxt = ST_IDLE;
                else if (byte_done) state_nxt = ST_DATA;
            end
            ST_DATA: if (end_frame) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        S_SPI_MISO_OE = (state != ST_IDLE);
        S_SPI_MISO    = (state == ST_DATA) & miso_q;
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            rx_sr        <= '0;
            tx_sr        <= '0;
            bit_cnt      <= '0;
            addr         <= '0;
            rw           <= 1'b0;
            miso_q       <= 1'b0;
            S_WR_STB     <= 1'b0;
            S_WR_ADDR    <= '0;
            S_WR_DATA    <= '0;
            S_FRAME_DONE <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= REG_RST;
        end else begin
            S_WR_STB     <= 1'b0;
            S_FRAME_DONE <= 1'b0;
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
                if (start) begin
                    rx_sr  <= '0;
                    miso_q <= 1'b0;
                end
            end else if (end_frame) begin
                // End of frame wins over a coincident sample edge; partial byte dropped.
                S_FRAME_DONE <= 1'b1;
                bit_cnt      <= '0;
                miso_q       <= 1'b0;
            end else begin
                if (sample_stb) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        if (state == ST_CMD) begin
                            rw   <= rx_byte[CMD_RW_BIT];
                            addr <= cmd_addr;
                            if (rx_byte[CMD_RW_BIT]) begin
                                tx_sr <= rd_reg(cmd_addr);
                                addr  <= addr_inc(cmd_addr);
                            end
                        end else if (rw) begin
                            tx_sr <= rd_reg(addr);
                            addr  <= addr_inc(addr);
                        end else begin
                            if (in_range(addr)) begin
                                regs[addr[AW-1:0]] <= rx_byte;
                                S_WR_STB           <= 1'b1;
                                S_WR_ADDR          <= addr[AW-1:0];
                                S_WR_DATA          <= rx_byte;
                            end
                            addr <= addr_inc(addr);
                        end
                    end
                end
                if (shift_stb && state == ST_DATA) begin
                    miso_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        S_REGS = '0;
        for (int unsigned i = 0; i < NREGS; i++) S_REGS[8*i +: 8] = regs[i];
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: table-driven SPI frames plus corner sequences.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

    localparam int unsigned NREGS = 16;
    localparam int unsigned HALF  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b1;
    logic                 cpol = 1'b0;
    logic                 cpha = 1'b0;
    logic                 cs = 1'b1;
    logic                 sck = 1'b0;
    logic                 mosi = 1'b0;
    logic                 miso;
    logic                 miso_oe;
    logic [NREGS*8-1:0]   regs;
    logic                 wr_stb;
    logic [3:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 frame_done;

    always #5 clk = ~clk;

    spi_slave_regfile #(
        .NREGS   (NREGS),
        .AW      (4),
        .REG_RST (8'h00)
    ) dut (
        .S_SYSCLK      (clk),
        .S_RESETN      (rst_n),
        .S_ENABLE      (en),
        .S_CPOL        (cpol),
        .S_CPHA        (cpha),
        .S_SPI_CS      (cs),
        .S_SPI_SCK     (sck),
        .S_SPI_MOSI    (mosi),
        .S_SPI_MISO    (miso),
        .S_SPI_MISO_OE (miso_oe),
        .S_REGS        (regs),
        .S_WR_STB      (wr_stb),
        .S_WR_ADDR     (wr_addr),
        .S_WR_DATA     (wr_data),
        .S_FRAME_DONE  (frame_done)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } stb_t;

    typedef struct {
        logic        cpol;
        logic        cpha;
        int          nbits;
        logic [23:0] tx;
        logic        rd;
        logic [15:0] exp_rd;
        int          nstb;
        stb_t        s0;
        stb_t        s1;
    } vec_t;

    stb_t       sbq[$];
    logic [7:0] exp_regs [NREGS];
    vec_t       vecs [10];
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic       oe_hi_seen = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // One sysclk step; the write-strobe scoreboard is serviced on every step.
    task automatic tick();
        @(negedge clk);
        if (wr_stb) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr_stb: got addr %0d data %0h, required no strobe",
                         wr_addr, wr_data);
            end else begin
                stb_t e;
                e = sbq.pop_front();
                chk("wr_addr", 128'(wr_addr), 128'(e.a));
                chk("wr_data", 128'(wr_data), 128'(e.d));
            end
        end
        if (frame_done) done_cnt++;
        if (miso_oe) oe_hi_seen = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input stb_t s);
        sbq.push_back(s);
        exp_regs[s.a] = s.d;
    endtask

    task automatic check_regs(input string nm);
        logic [NREGS*8-1:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = exp_regs[i];
        chk(nm, 128'(regs), 128'(f));
    endtask

    // Master side: tx right-aligned, MSB first; samples MISO just before its sample edge.
    task automatic spi_bits(input logic cp, input logic ch, input int nbits,
                            input logic [23:0] tx, output logic [23:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!ch) begin
                mosi = tx[i];
                cycles(HALF);
                rx  = {rx[22:0], miso};
                sck = ~cp;
                cycles(HALF);
                sck = cp;
            end else begin
                sck  = ~cp;
                mosi = tx[i];
                cycles(HALF);
                rx  = {rx[22:0], miso};
                sck = cp;
                cycles(HALF);
            end
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v, input int exp_done, input logic exp_oe);
        logic [23:0] rx;
        cpol = v.cpol;
        cpha = v.cpha;
        sck  = v.cpol;
        cycles(6);
        done_cnt   = 0;
        oe_hi_seen = 1'b0;
        if (v.nstb > 0) push(v.s0);
        if (v.nstb > 1) push(v.s1);
        cs = 1'b0;
        cycles(HALF);
        spi_bits(v.cpol, v.cpha, v.nbits, v.tx, rx);
        cycles(HALF);
        cs = 1'b1;
        cycles(10);
        if (v.rd) chk({nm, "_read"}, 128'(rx), 128'({8'h00, v.exp_rd}));
        chk({nm, "_sbq_empty"}, 128'(sbq.size()), 128'(0));
        chk({nm, "_frame_done"}, 128'(done_cnt), 128'(exp_done));
        chk({nm, "_oe_in_frame"}, 128'(oe_hi_seen), 128'(exp_oe));
        chk({nm, "_oe_after"}, 128'(miso_oe), 128'(0));
        check_regs({nm, "_regs"});
    endtask

    function automatic vec_t mkv(input logic cp, input logic ch, input int nb,
                                 input logic [23:0] tx, input logic rd, input logic [15:0] er,
                                 input int ns, input logic [3:0] a0, input logic [7:0] d0,
                                 input logic [3:0] a1, input logic [7:0] d1);
        vec_t v;
        v.cpol = cp;  v.cpha = ch;  v.nbits = nb;  v.tx = tx;
        v.rd = rd;    v.exp_rd = er; v.nstb = ns;
        v.s0.a = a0;  v.s0.d = d0;  v.s1.a = a1;  v.s1.d = d1;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rx;
        vec_t        v;
        stb_t        s;

        for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;

        vecs[0] = mkv(0, 0, 24, {8'h03, 8'hA5, 8'h5A}, 0, 16'h0000, 2, 4'd3, 8'hA5, 4'd4, 8'h5A);
        vecs[1] = mkv(1, 1, 24, {8'h83, 8'h00, 8'h00}, 1, 16'hA55A, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        vecs[2] = mkv(0, 0, 13, {11'h0, 8'h05, 5'b10110}, 0, 16'h0000, 0, 4'd0, 8'h00, 4'd0, 8'h00);
`ifdef SPI_SLV_ADDR_WRAP_EN
        vecs[3] = mkv(0, 0, 24, {8'h0F, 8'h11, 8'h22}, 0, 16'h0000, 2, 4'd15, 8'h11, 4'd0, 8'h22);
        vecs[5] = mkv(1, 0, 24, {8'h8F, 8'h00, 8'h00}, 1, 16'h1122, 0, 4'd0, 8'h00, 4'd0, 8'h00);
`else
        vecs[3] = mkv(0, 0, 24, {8'h0F, 8'h11, 8'h22}, 0, 16'h0000, 1, 4'd15, 8'h11, 4'd0, 8'h00);
        vecs[5] = mkv(1, 0, 24, {8'h8F, 8'h00, 8'h00}, 1, 16'h1100, 0, 4'd0, 8'h00, 4'd0, 8'h00);
`endif
        vecs[4] = mkv(0, 1, 24, {8'h90, 8'h00, 8'h00}, 1, 16'h0000, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        vecs[6] = mkv(0, 1, 24, {8'h7E, 8'h33, 8'h44}, 0, 16'h0000, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        vecs[7] = mkv(1, 0, 24, {8'h00, 8'hC3, 8'h3C}, 0, 16'h0000, 2, 4'd0, 8'hC3, 4'd1, 8'h3C);
        vecs[8] = mkv(0, 0, 24, {8'h80, 8'h00, 8'h00}, 1, 16'hC33C, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        vecs[9] = mkv(1, 1, 24, {8'h0E, 8'h66, 8'h77}, 0, 16'h0000, 2, 4'd14, 8'h66, 4'd15, 8'h77);

        // Reset state
        cycles(3);
        check_regs("rst_regs");
        chk("rst_outputs", 128'({wr_stb, wr_addr, wr_data, frame_done, miso, miso_oe}), 128'(0));
        rst_n = 1'b1;
        cycles(5);

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i], 1, 1'b1);

        // Reset asserted mid-byte; the rest of that CS-low period must be ignored.
        cpol = 0; cpha = 0; sck = 0;
        cycles(6);
        done_cnt = 0;
        oe_hi_seen = 1'b0;
        cs = 1'b0;
        cycles(HALF);
        spi_bits(0, 0, 11, {13'h0, 8'h02, 3'b101}, rx);
        rst_n = 1'b0;
        cycles(2);
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
        check_regs("midrst_regs");
        chk("midrst_outputs", 128'({wr_stb, wr_addr, wr_data, frame_done, miso, miso_oe}), 128'(0));
        rst_n = 1'b1;
        cycles(4);
        oe_hi_seen = 1'b0;
        spi_bits(0, 0, 8, 24'h0000FF, rx);
        cycles(HALF);
        cs = 1'b1;
        cycles(10);
        chk("midrst_oe_ignored", 128'(oe_hi_seen), 128'(0));
        chk("midrst_no_done", 128'(done_cnt), 128'(0));
        check_regs("midrst_regs_after");
        v = mkv(0, 0, 16, {8'h00, 8'h02, 8'h77}, 0, 16'h0000, 1, 4'd2, 8'h77, 4'd0, 8'h00);
        run_vec("postrst_wr", v, 1, 1'b1);
        v = mkv(0, 1, 16, {8'h00, 8'h82, 8'h00}, 1, 16'h0077, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        run_vec("postrst_rd", v, 1, 1'b1);

        // Disabled block ignores a complete write frame.
        en = 1'b0;
        v = mkv(0, 0, 16, {8'h00, 8'h06, 8'h99}, 0, 16'h0000, 0, 4'd0, 8'h00, 4'd0, 8'h00);
        run_vec("disabled", v, 0, 1'b0);
        en = 1'b1;
        cycles(4);

        // Enable dropped mid-frame after one full data byte behaves as CS rise.
        cpol = 0; cpha = 1; sck = 0;
        cycles(6);
        done_cnt = 0;
        s.a = 4'd7;
        s.d = 8'hE1;
        push(s);
        cs = 1'b0;
        cycles(HALF);
        spi_bits(0, 1, 18, {6'h0, 8'h07, 8'hE1, 2'b11}, rx);
        en = 1'b0;
        cycles(6);
        chk("endrop_oe", 128'(miso_oe), 128'(0));
        chk("endrop_done", 128'(done_cnt), 128'(1));
        chk("endrop_sbq_empty", 128'(sbq.size()), 128'(0));
        cs = 1'b1;
        cycles(6);
        en = 1'b1;
        cycles(6);
        chk("endrop_done_once", 128'(done_cnt), 128'(1));
        check_regs("endrop_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI slave responder that exposes a bank of 8-bit registers to an external SPI master, such as spi_intface.
- Each frame starts with a command byte: bit7 = R/nW, bits6:0 = start address. Data bytes follow, and the address auto-increments after each one.
- SPI pins are oversampled in the S_SYSCLK domain. Register contents are presented in parallel to system logic, with a write strobe for each completed write.

Parameters:
NREGS, 16, number of 8-bit registers (1..128)
AW, 4, register address width, $clog2(NREGS)
REG_RST, 8'h00, reset value of every register

Ports:
S_SYSCLK  in  1  system clock; only clock; must be at least 8x SCK frequency
S_RESETN  in  1  asynchronous active-low reset
S_ENABLE  in  1  block enable; low = ignore SPI, MISO_OE=0
S_CPOL  in  1  SCK idle level
S_CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge
S_SPI_CS  in  1  chip select, active low
S_SPI_SCK  in  1  SPI clock from master
S_SPI_MOSI  in  1  serial data in, MSB first
S_SPI_MISO  out  1  serial data out, MSB first
S_SPI_MISO_OE  out  1  MISO output enable (tri-state control at top level)
S_REGS  out  NREGS*8  flattened register contents; reg i = bits [8i+7:8i]
S_WR_STB  out  1  one-cycle pulse when an SPI write commits
S_WR_ADDR  out  AW  address of committed write
S_WR_DATA  out  8  data of committed write
S_FRAME_DONE  out  1  one-cycle pulse on CS deassert ending an active frame

Behaviour:
- Reset: all registers = REG_RST; all outputs 0; FSM in IDLE; shift and bit counters cleared. Reset mid-frame aborts the frame; the current frame is ignored until CS goes high and then low again.
- Synchronisation: CS, SCK and MOSI each pass through a 2-FF synchroniser. Edge detect adds one more cycle, so an action occurs 3 S_SYSCLK after the pin edge.
  - Leading edge = SCK leaving S_CPOL. Trailing edge = SCK returning to S_CPOL.
  - Sample edge = leading edge if CPHA=0, otherwise trailing edge. Shift edge = the other edge.
- FSM states:
  - IDLE -> CMD on synchronised CS falling edge while S_ENABLE=1. MISO_OE=1 while CS is low; MISO=0 during CMD.
  - CMD: 8 sample edges shift MOSI into rx_sr. On the 8th sample edge, latch addr=cmd[6:0] and rw=cmd[7], then enter DATA.
    - Read: load tx_sr with reg[addr] (or 8'h00 if out of range), then addr++.
  - DATA: every shift edge sets MISO <= tx_sr[7] and shifts tx_sr left. This rule alone provides the correct MSB timing in both CPHA modes.
  - DATA: every 8th sample edge completes a byte.
    - Write: reg[addr] <= rx byte; S_WR_STB/ADDR/DATA valid on the following cycle; addr++.
    - Read: reload tx_sr from reg[addr]; addr++.
  - Any state -> IDLE on CS rise: pulse S_FRAME_DONE if the state was not IDLE; partial byte discarded with no write; MISO_OE=0; bit counter cleared.
- Simultaneous events:
  - CS rise in the same cycle as a sample edge: CS wins and the edge is ignored.
  - S_ENABLE falling mid-frame behaves as a CS rise.
- Addressing: the 7-bit addr increments and saturates at 127. Addresses >= NREGS drop writes (no strobe) and return 8'h00 on reads.
- Back-to-back frames need no idle time beyond 3 sysclk of CS high.

Optional Feature:
SPI_SLV_ADDR_WRAP_EN
- Defined: auto-increment wraps NREGS-1 -> 0, so a burst cycles through the bank. A start address >= NREGS is still out of range and does not wrap.
- Undefined: the saturating and out-of-range behaviour described in Behaviour applies.

Decomposition:
- Shared package: command bit positions (CMD_RW_BIT=7, CMD_ADDR_HI=6, CMD_ADDR_LO=0), FSM state encodings (IDLE/CMD/DATA), and the synchroniser depth constant.
- Natural sub-module: spi_slv_pin_sync, covering the 2-FF synchronisers plus leading/trailing/CS edge detect with CPOL/CPHA decoding. It outputs sample_stb, shift_stb, cs_fall, cs_rise and mosi_s.

Test Plan:
- Mode 0, SCK = sysclk/16, frame 0x03 0xA5 0x5A -> reg3=0xA5, reg4=0x5A; two S_WR_STB pulses with ADDR 3 then 4; one S_FRAME_DONE.
- Mode 3 (CPOL=1, CPHA=1), preload reg3=0xA5 via write, then frame 0x83 0x00 0x00 -> master receives 0xA5 then reg4 value; no S_WR_STB.
- Write frame 0x05 followed by CS rise after 5 data bits -> reg5 unchanged, no strobe, S_FRAME_DONE pulses, MISO_OE=0.
- Write frame 0x0F 0x11 0x22 with NREGS=16 -> macro off: reg15=0x11, second byte dropped. Macro on: reg15=0x11, reg0=0x22.
- Read frame 0x90 (address 16, out of range) -> returns 0x00. Also: reset asserted mid-byte -> all S_REGS=REG_RST and outputs 0; the next full frame works normally.
- S_ENABLE=0 with a complete write frame -> no register change, MISO_OE stays 0.
